// File: rtl/lp_smpl_queue.sv
// Stereo sample history buffer that replays the READ_LEN newest samples as a burst for a FIR.
// Optional dropped-trigger counter enabled by defining SMPL_QUEUE_OVR_CNT_EN.
module lp_smpl_queue #(
    parameter int DEPTH    = 1024,
    parameter int READ_LEN = 1021
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] lft_smpl,
    input  logic signed [15:0] rght_smpl,
    input  logic               wrt_smpl,
    output logic signed [15:0] lft_out,
    output logic signed [15:0] rght_out,
    output logic               sequencing,
    output logic               primed,
    output logic [7:0]         ovr_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(READ_LEN + 1);
    localparam logic [AW-1:0] RL_A    = AW'(READ_LEN);
    localparam logic [CW-1:0] RL_C    = CW'(READ_LEN);
    localparam logic [CW-1:0] RL_LAST = CW'(READ_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEQ  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic signed [15:0] r_mem_l [DEPTH];
    logic signed [15:0] r_mem_r [DEPTH];
    logic signed [15:0] r_rd_l;
    logic signed [15:0] r_rd_r;
    logic [AW-1:0]      r_new_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      w_rd_addr;
    logic [AW-1:0]      w_load_addr;
    logic [CW-1:0]      r_fill;
    logic [CW-1:0]      w_fill_inc;
    logic [CW-1:0]      r_seq_cnt;
    logic               r_pend;
    logic               w_pend_nxt;
    logic               w_trig;
    logic               w_seq_last;

    assign w_fill_inc  = (r_fill == RL_C) ? RL_C : (r_fill + CW'(1));
    assign w_trig      = wrt_smpl & (w_fill_inc == RL_C);
    assign w_load_addr = r_new_ptr - RL_A;
    assign w_seq_last  = (r_seq_cnt == RL_LAST);

    // Sample storage with registered read; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wrt_smpl) begin
            r_mem_l[r_new_ptr] <= lft_smpl;
            r_mem_r[r_new_ptr] <= rght_smpl;
        end
        r_rd_l <= r_mem_l[w_rd_addr];
        r_rd_r <= r_mem_r[w_rd_addr];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, pending-flag and read-address selection.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_rd_addr   = r_rd_ptr;
        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                w_rd_addr   = w_load_addr;
                w_state_nxt = SEQ;
                if (w_trig) begin
                    w_pend_nxt = 1'b1;
                end else begin
                    w_pend_nxt = r_pend;
                end
            end
            SEQ: begin
                if (w_seq_last) begin
                    // A trigger on the final cycle is folded straight into the next LOAD.
                    if (r_pend || w_trig) begin
                        w_state_nxt = LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                    w_pend_nxt = 1'b0;
                end else begin
                    w_state_nxt = SEQ;
                    if (w_trig) begin
                        w_pend_nxt = 1'b1;
                    end else begin
                        w_pend_nxt = r_pend;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    // Pointers, fill level, burst counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_new_ptr  <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_seq_cnt  <= '0;
            r_pend     <= 1'b0;
            primed     <= 1'b0;
            sequencing <= 1'b0;
            lft_out    <= 16'sd0;
            rght_out   <= 16'sd0;
        end else begin
            if (wrt_smpl) begin
                r_new_ptr <= r_new_ptr + AW'(1);
                r_fill    <= w_fill_inc;
                primed    <= (w_fill_inc == RL_C);
            end
            r_pend <= w_pend_nxt;
            case (r_state)
                LOAD: begin
                    r_rd_ptr  <= w_load_addr + AW'(1);
                    r_seq_cnt <= '0;
                end
                SEQ: begin
                    r_rd_ptr  <= r_rd_ptr + AW'(1);
                    r_seq_cnt <= r_seq_cnt + CW'(1);
                end
                default: begin
                    r_rd_ptr  <= r_rd_ptr;
                    r_seq_cnt <= r_seq_cnt;
                end
            endcase
            // Output stage trails the memory read by one cycle, so SEQ cycles line up with data.
            sequencing <= (r_state == SEQ);
            if (r_state == SEQ) begin
                lft_out  <= r_rd_l;
                rght_out <= r_rd_r;
            end
        end
    end

`ifdef SMPL_QUEUE_OVR_CNT_EN
    logic       w_drop;
    logic [7:0] r_ovr_cnt;

    assign w_drop = w_trig & r_pend & (r_state != IDLE);

    // Saturating count of triggers lost because a burst was already pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovr_cnt <= 8'd0;
        end else if (w_drop && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    assign ovr_cnt = r_ovr_cnt;
`else
    assign ovr_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_lp_smpl_queue.sv
// Scoreboard bench for lp_smpl_queue: small DEPTH=8/READ_LEN=5 instance plus a default-size ramp instance.
module tb_lp_smpl_queue;

    localparam int R = 5;

    logic               clk;
    logic               rst_n;
    logic signed [15:0] lft_smpl, rght_smpl;
    logic               wrt_smpl;
    logic signed [15:0] lft_out, rght_out;
    logic               sequencing, primed;
    logic [7:0]         ovr_cnt;

    logic signed [15:0] b_lft_smpl, b_rght_smpl;
    logic               b_wrt;
    logic signed [15:0] b_lft_out, b_rght_out;
    logic               b_seq, b_primed;
    logic [7:0]         b_ovr;

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;
    bit mon_en = 1'b0;

    int hist_e[$];
    int hist_v[$];
    int sched[$];
    int tb_fill, tb_drop, last_S;
    int last_l, last_r;

    int m_k, m_n, m_idx, m_ev;
    bit m_exp;

    lp_smpl_queue #(.DEPTH(8), .READ_LEN(R)) dut (
        .clk(clk), .rst_n(rst_n), .lft_smpl(lft_smpl), .rght_smpl(rght_smpl),
        .wrt_smpl(wrt_smpl), .lft_out(lft_out), .rght_out(rght_out),
        .sequencing(sequencing), .primed(primed), .ovr_cnt(ovr_cnt)
    );

    lp_smpl_queue dut_big (
        .clk(clk), .rst_n(rst_n), .lft_smpl(b_lft_smpl), .rght_smpl(b_rght_smpl),
        .wrt_smpl(b_wrt), .lft_out(b_lft_out), .rght_out(b_rght_out),
        .sequencing(b_seq), .primed(b_primed), .ovr_cnt(b_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic signed [15:0] rfun(input int v);
        logic [15:0] t;
        t = 16'(v) ^ 16'h5A5A;
        return $signed(t);
    endfunction

    function automatic int exp_ovr();
`ifdef SMPL_QUEUE_OVR_CNT_EN
        return (tb_drop > 255) ? 255 : tb_drop;
`else
        return 0;
`endif
    endfunction

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge; the following rising edge applies the reset.
    task automatic do_reset();
        rst_n   = 1'b0;
        sched.delete();
        tb_fill = 0;
        tb_drop = 0;
        last_S  = -1000;
        last_l  = 0;
        last_r  = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one write; on return edge_n is the edge that sampled it.
    task automatic wr(input int v);
        int e;
        lft_smpl  = 16'(v);
        rght_smpl = rfun(v);
        wrt_smpl  = 1'b1;
        @(negedge clk);
        wrt_smpl = 1'b0;
        e = edge_n;
        hist_e.push_back(e);
        hist_v.push_back(v);
        if (tb_fill < R) tb_fill++;
        if (tb_fill == R) begin
            if (e > last_S + R - 1) begin
                last_S = e + 2;
                sched.push_back(last_S);
            end else if (e >= last_S - 1) begin
                last_S = last_S + R + 1;
                sched.push_back(last_S);
            end else begin
                tb_drop++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: burst k of a burst starting at S carries the k-th oldest of the R newest writes sampled by edge S-2.
    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            m_exp = 1'b0;
            m_k   = 0;
            if (sched.size() > 0) begin
                if (edge_n >= sched[0] && edge_n <= sched[0] + R - 1) begin
                    m_exp = 1'b1;
                    m_k   = edge_n - sched[0];
                end
            end
            check_val("seq", {31'd0, sequencing}, {31'd0, m_exp});
            if (m_exp) begin
                m_n = 0;
                foreach (hist_e[i]) if (hist_e[i] <= sched[0] - 2) m_n++;
                m_idx  = m_n - R + m_k;
                m_ev   = (m_idx >= 0) ? hist_v[m_idx] : 0;
                last_l = m_ev;
                last_r = rfun(m_ev);
                check_val("lft", lft_out, last_l);
                check_val("rght", rght_out, last_r);
                if (m_k == R - 1) void'(sched.pop_front());
            end else begin
                check_val("lft_hold", lft_out, last_l);
                check_val("rght_hold", rght_out, last_r);
            end
        end
    end

    initial begin
        rst_n = 1'b0; wrt_smpl = 1'b0; lft_smpl = 16'sd0; rght_smpl = 16'sd0;
        b_wrt = 1'b0; b_lft_smpl = 16'sd0; b_rght_smpl = 16'sd0;
        tb_fill = 0; tb_drop = 0; last_S = -1000; last_l = 0; last_r = 0;
        repeat (3) @(negedge clk);
        check_val("rst_seq", {31'd0, sequencing}, 0);
        check_val("rst_primed", {31'd0, primed}, 0);
        check_val("rst_lft", lft_out, 0);
        check_val("rst_rght", rght_out, 0);
        check_val("rst_ovr", {24'd0, ovr_cnt}, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // First fill: no burst until the fifth write.
        for (int v = 1; v <= 4; v++) begin
            wr(v);
            check_val("primed_lo", {31'd0, primed}, 0);
            idle(2);
        end
        wr(5);
        check_val("primed_hi", {31'd0, primed}, 1);
        idle(10);

        // Isolated writes; bursts wrap across the end of the buffer.
        for (int v = 6; v <= 12; v++) begin
            wr(v);
            idle(9);
        end
        check_val("ovr_single", {24'd0, ovr_cnt}, exp_ovr());

        // One write during a burst -> pending burst after one idle cycle.
        do_reset();
        for (int v = 1; v <= 5; v++) wr(v);
        idle(2);
        wr(6);
        idle(15);
        check_val("ovr_pend", {24'd0, ovr_cnt}, exp_ovr());

        // Two writes during a burst -> one pending, one dropped.
        do_reset();
        for (int v = 1; v <= 5; v++) wr(v);
        idle(2);
        wr(6);
        wr(7);
        idle(15);
        check_val("ovr_drop", {24'd0, ovr_cnt}, exp_ovr());

        // Trigger on the final SEQ cycle is honoured.
        wr(8);
        idle(5);
        wr(9);
        idle(16);
        check_val("ovr_last", {24'd0, ovr_cnt}, exp_ovr());

        // Reset on the second burst cycle, then a full refill is needed.
        wr(10);
        idle(2);
        do_reset();
        check_val("mid_rst_seq", {31'd0, sequencing}, 0);
        check_val("mid_rst_primed", {31'd0, primed}, 0);
        for (int v = 31; v <= 34; v++) begin
            wr(v);
            idle(3);
        end
        check_val("refill_primed_lo", {31'd0, primed}, 0);
        wr(35);
        check_val("refill_primed_hi", {31'd0, primed}, 1);
        idle(12);

        // Default-size instance: 1021-sample ramp written back to back.
        for (int v = 1; v <= 1021; v++) begin
            b_lft_smpl  = 16'(v);
            b_rght_smpl = rfun(v);
            b_wrt       = 1'b1;
            @(negedge clk);
        end
        b_wrt = 1'b0;
        check_val("big_primed", {31'd0, b_primed}, 1);
        @(posedge clk); #1;
        check_val("big_lat", {31'd0, b_seq}, 0);
        for (int k = 0; k < 1021; k++) begin
            @(posedge clk); #1;
            check_val("big_seq", {31'd0, b_seq}, 1);
            check_val("big_lft", b_lft_out, k + 1);
            check_val("big_rght", b_rght_out, rfun(k + 1));
        end
        @(posedge clk); #1;
        check_val("big_end", {31'd0, b_seq}, 0);
        check_val("big_ovr", {24'd0, b_ovr}, 0);

        idle(2);
        check_val("sb_empty", sched.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
